csr_req_sequencer: RTL and testbench
====================================

CSR_REQ_SEQUENCER -- requirements
Module: csr_req_sequencer

Interface
REQ-001 Parameter MAX_REPLAY, default 7, SHALL set the maximum number of re-issues after csr_replay_i before the request is aborted (range 1-15).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the watchdog limit in cycles (used only with REQ-027).
REQ-003 Ports SHALL be:
- clk_i  in  1  clock; all state updates on the rising edge
- rstn_i  in  1  asynchronous active-low reset
- valid_i  in  1  commit presents a CSR/system op
- kill_i  in  1  flush from control unit
- csr_addr_i  in  12  CSR address or system immediate
- csr_cmd_i  in  3  csr_cmd_t command
- csr_data_i  in  64  write data
- pc_i  in  64  instruction PC
- csr_rdata_i  in  64  CSR read data
- csr_replay_i  in  1  CSR busy, re-issue
- csr_stall_i  in  1  multi-cycle operation in progress
- csr_exception_i  in  1  CSR exception
- csr_eret_i  in  1  return from trap
- csr_evec_i  in  64  redirect target
- csr_req_valid_o  out  1  request strobe to CSR file
- csr_rw_addr_o  out  12  latched address
- csr_rw_cmd_o  out  3  latched command
- csr_rw_data_o  out  64  latched write data
- csr_pc_o  out  64  latched PC
- busy_o  out  1  stall request to control unit
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  64  captured read data
- xcpt_o  out  1  exception/abort, qualified by done_o
- eret_o  out  1  eret, qualified by done_o
- evec_o  out  64  redirect target, qualified by done_o

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, RESP, WAIT, DONE.
REQ-005 IDLE->ISSUE when valid_i=1, kill_i=0 and csr_cmd_i!=CSR_CMD_NOPE; addr, cmd, data and pc SHALL be latched on that edge.
REQ-006 valid_i with csr_cmd_i=CSR_CMD_NOPE SHALL be ignored.
REQ-007 ISSUE SHALL drive csr_req_valid_o=1 for exactly one cycle and then go to RESP.
REQ-008 In RESP, csr_replay_i=1 with replay count <MAX_REPLAY SHALL increment the count and return to ISSUE. The re-issue occurs 2 cycles after the previous strobe.
REQ-009 In RESP, csr_replay_i=1 with count ==MAX_REPLAY SHALL go to DONE with xcpt_o=1.
REQ-010 In RESP, csr_replay_i=0 and csr_stall_i=1 SHALL go to WAIT.
REQ-011 In RESP, csr_replay_i=0 and csr_stall_i=0 SHALL capture rdata, exception, eret and evec and go to DONE.
REQ-012 WAIT SHALL hold until csr_stall_i=0, then capture as in REQ-011 that cycle and go to DONE.
REQ-013 csr_replay_i SHALL take priority over csr_stall_i in RESP.
REQ-014 DONE SHALL assert done_o for one cycle with captured values and return to IDLE. A new request is accepted the following cycle.
REQ-015 busy_o SHALL be 1 in ISSUE, RESP and WAIT, and 0 in IDLE and DONE.
REQ-016 valid_i arriving while not IDLE SHALL be ignored (commit holds it under busy_o).
REQ-017 kill_i=1 in any state SHALL force IDLE next cycle with no done_o pulse.
REQ-018 kill_i=1 SHALL suppress csr_req_valid_o in the same cycle.
REQ-019 kill_i SHALL take priority over every other transition.
REQ-020 Replay count SHALL be 4 bits, clear on entry to ISSUE from IDLE, and never wrap.
REQ-021 csr_rw_*_o and csr_pc_o SHALL remain stable from ISSUE through DONE.

Reset
REQ-022 rstn_i=0 SHALL immediately force state IDLE and replay count 0.
REQ-023 rstn_i=0 SHALL immediately force every output to 0.
REQ-024 Reset asserted mid-request SHALL abandon the request without a done_o pulse.
REQ-025 Release of reset SHALL be synchronised by the integrator; the first request is accepted on the first edge after release.

Configuration
REQ-026 Macro CSR_SEQ_TIMEOUT_EN SHALL gate a watchdog.
REQ-027 With CSR_SEQ_TIMEOUT_EN defined:
- an 8-bit counter SHALL count cycles spent in WAIT
- when it reaches TIMEOUT_CYCLES, the FSM SHALL go to DONE with xcpt_o=1 and rdata_o=0
- the counter SHALL clear on leaving WAIT
REQ-028 Without CSR_SEQ_TIMEOUT_EN, WAIT SHALL be held indefinitely and no counter logic SHALL exist.

Verification
REQ-029 Bench SHALL cover the following directed scenarios:
- CSRRW, addr 0x300, data 0xA5, no replay or stall -> strobe at cycle 1, done_o at cycle 3, rdata_o=csr_rdata_i, busy_o high for 2 cycles.
- csr_replay_i high for 2 RESP cycles -> 3 strobes total, 2 cycles apart, then done_o, xcpt_o=0.
- csr_replay_i held high with MAX_REPLAY=7 -> 8 strobes, then done_o with xcpt_o=1.
- csr_stall_i high for 10 cycles after strobe -> busy_o held, done_o one cycle after stall drops; with CSR_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=4 -> done_o with xcpt_o=1 after 4 WAIT cycles.
- kill_i in RESP, and rstn_i low in WAIT -> IDLE, no done_o, all outputs 0 on reset; next valid_i accepted.
- valid_i with CSR_CMD_NOPE, and valid_i during busy -> no strobe, no state change.

Source files
------------

// File: rtl/csr_req_sequencer_if.sv
// Commit/CSR-file side signal bundle for csr_req_sequencer.
// The slave modport is the sequencer's view; master is the environment driving it.
interface csr_req_sequencer_if;
  logic        valid_i;
  logic        kill_i;
  logic [11:0] csr_addr_i;
  logic [2:0]  csr_cmd_i;
  logic [63:0] csr_data_i;
  logic [63:0] pc_i;
  logic [63:0] csr_rdata_i;
  logic        csr_replay_i;
  logic        csr_stall_i;
  logic        csr_exception_i;
  logic        csr_eret_i;
  logic [63:0] csr_evec_i;

  logic        csr_req_valid_o;
  logic [11:0] csr_rw_addr_o;
  logic [2:0]  csr_rw_cmd_o;
  logic [63:0] csr_rw_data_o;
  logic [63:0] csr_pc_o;
  logic        busy_o;
  logic        done_o;
  logic [63:0] rdata_o;
  logic        xcpt_o;
  logic        eret_o;
  logic [63:0] evec_o;

  modport master (
    output valid_i, kill_i, csr_addr_i, csr_cmd_i, csr_data_i, pc_i, csr_rdata_i,
    output csr_replay_i, csr_stall_i, csr_exception_i, csr_eret_i, csr_evec_i,
    input  csr_req_valid_o, csr_rw_addr_o, csr_rw_cmd_o, csr_rw_data_o, csr_pc_o,
    input  busy_o, done_o, rdata_o, xcpt_o, eret_o, evec_o
  );

  modport slave (
    input  valid_i, kill_i, csr_addr_i, csr_cmd_i, csr_data_i, pc_i, csr_rdata_i,
    input  csr_replay_i, csr_stall_i, csr_exception_i, csr_eret_i, csr_evec_i,
    output csr_req_valid_o, csr_rw_addr_o, csr_rw_cmd_o, csr_rw_data_o, csr_pc_o,
    output busy_o, done_o, rdata_o, xcpt_o, eret_o, evec_o
  );
endinterface

// File: rtl/csr_req_sequencer.sv
// Sequences one committed CSR/system op into the CSR file, handling replay, stall and kill.
// Optional WAIT watchdog enabled by defining CSR_SEQ_TIMEOUT_EN.
module csr_req_sequencer #(
  parameter int unsigned MAX_REPLAY     = 7,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                 clk_i,
  input logic                 rstn_i,
  csr_req_sequencer_if.slave  bus_io
);

  if (MAX_REPLAY < 1 || MAX_REPLAY > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255)
  begin : g_bad_param
    $error("csr_req_sequencer: parameter out of range");
  end

  localparam logic [2:0] CmdNope   = 3'd0;
  localparam logic [3:0] MaxReplay = 4'(MAX_REPLAY);

  typedef enum logic [2:0] {StIdle, StIssue, StResp, StWait, StDone} state_e;

  state_e      state_q;
  logic [3:0]  replay_cnt_q;
  logic        req_q;
  logic        busy_q;
  logic        done_q;
  logic        xcpt_q;
  logic        eret_q;
  logic [11:0] addr_q;
  logic [2:0]  cmd_q;
  logic [63:0] data_q;
  logic [63:0] pc_q;
  logic [63:0] rdata_q;
  logic [63:0] evec_q;

`ifdef CSR_SEQ_TIMEOUT_EN
  localparam logic [7:0] WdLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wd_cnt_q;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= StIdle;
      replay_cnt_q <= '0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      xcpt_q       <= 1'b0;
      eret_q       <= 1'b0;
      addr_q       <= '0;
      cmd_q        <= '0;
      data_q       <= '0;
      pc_q         <= '0;
      rdata_q      <= '0;
      evec_q       <= '0;
`ifdef CSR_SEQ_TIMEOUT_EN
      wd_cnt_q     <= '0;
`endif
    end else if (bus_io.kill_i) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CSR_SEQ_TIMEOUT_EN
      wd_cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.valid_i && bus_io.csr_cmd_i != CmdNope) begin
            addr_q       <= bus_io.csr_addr_i;
            cmd_q        <= bus_io.csr_cmd_i;
            data_q       <= bus_io.csr_data_i;
            pc_q         <= bus_io.pc_i;
            replay_cnt_q <= '0;
            req_q        <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          req_q   <= 1'b0;
          state_q <= StResp;
        end
        StResp: begin
          if (bus_io.csr_replay_i) begin
            if (replay_cnt_q < MaxReplay) begin
              replay_cnt_q <= replay_cnt_q + 4'd1;
              req_q        <= 1'b1;
              state_q      <= StIssue;
            end else begin
              // Replay budget exhausted: abort as an exception.
              rdata_q <= '0;
              xcpt_q  <= 1'b1;
              eret_q  <= 1'b0;
              evec_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end else if (bus_io.csr_stall_i) begin
            state_q <= StWait;
          end else begin
            rdata_q <= bus_io.csr_rdata_i;
            xcpt_q  <= bus_io.csr_exception_i;
            eret_q  <= bus_io.csr_eret_i;
            evec_q  <= bus_io.csr_evec_i;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StWait: begin
          if (!bus_io.csr_stall_i) begin
            rdata_q <= bus_io.csr_rdata_i;
            xcpt_q  <= bus_io.csr_exception_i;
            eret_q  <= bus_io.csr_eret_i;
            evec_q  <= bus_io.csr_evec_i;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
`ifdef CSR_SEQ_TIMEOUT_EN
            wd_cnt_q <= '0;
          end else if (wd_cnt_q == WdLast) begin
            rdata_q  <= '0;
            xcpt_q   <= 1'b1;
            eret_q   <= 1'b0;
            evec_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
            wd_cnt_q <= '0;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
`endif
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A kill in the issue cycle must not reach the CSR file.
  assign bus_io.csr_req_valid_o = req_q & ~bus_io.kill_i;
  assign bus_io.csr_rw_addr_o   = addr_q;
  assign bus_io.csr_rw_cmd_o    = cmd_q;
  assign bus_io.csr_rw_data_o   = data_q;
  assign bus_io.csr_pc_o        = pc_q;
  assign bus_io.busy_o          = busy_q;
  assign bus_io.done_o          = done_q;
  assign bus_io.rdata_o         = rdata_q;
  assign bus_io.xcpt_o          = xcpt_q;
  assign bus_io.eret_o          = eret_q;
  assign bus_io.evec_o          = evec_q;

endmodule

// File: tb/tb_csr_req_sequencer.sv
// Self-checking bench for csr_req_sequencer: directed scenarios plus randomized transactions
// checked against a cycle-schedule model derived from the sequencing rules.
module tb_csr_req_sequencer;

  localparam int MAXR   = 7;
  localparam int TB_TO  = 4;
  localparam logic [2:0] CMD_NOPE  = 3'd0;
  localparam logic [2:0] CMD_CSRRW = 3'd1;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  csr_req_sequencer_if bus_if ();

  csr_req_sequencer #(
    .MAX_REPLAY     (MAXR),
    .TIMEOUT_CYCLES (TB_TO)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus_io (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus_if.valid_i         = 1'b0;
    bus_if.kill_i          = 1'b0;
    bus_if.csr_addr_i      = '0;
    bus_if.csr_cmd_i       = CMD_NOPE;
    bus_if.csr_data_i      = '0;
    bus_if.pc_i            = '0;
    bus_if.csr_rdata_i     = '0;
    bus_if.csr_replay_i    = 1'b0;
    bus_if.csr_stall_i     = 1'b0;
    bus_if.csr_exception_i = 1'b0;
    bus_if.csr_eret_i      = 1'b0;
    bus_if.csr_evec_i      = '0;
  endtask

  // One full request. Expected timing: strobe j at cycle 1+2j, response after the last
  // strobe, done one cycle after the capturing cycle.
  task automatic run_txn(input string name, input logic [2:0] cmd, input logic [11:0] addr,
                         input logic [63:0] wdata, input int nrep, input int nstall);
    int   k, resp, done_c, cap_c, rep_end, strobes;
    bit   abort, tmo;
    logic [63:0] pc, exp_rdata, exp_evec;
    logic exp_xcpt, exp_eret, exp_req, exp_busy, exp_done;
    pc        = {$urandom, $urandom};
    abort     = (nrep > MAXR);
    k         = abort ? MAXR + 1 : nrep + 1;
    resp      = 2 * k;
    rep_end   = 2 * (abort ? MAXR + 1 : nrep);
    tmo       = 1'b0;
`ifdef CSR_SEQ_TIMEOUT_EN
    tmo = !abort && (nstall > TB_TO);
`endif
    if (abort)    done_c = resp + 1;
    else if (tmo) done_c = resp + TB_TO + 1;
    else          done_c = resp + nstall + 1;
    cap_c     = done_c - 1;
    strobes   = 0;
    exp_rdata = '0;
    exp_evec  = '0;
    exp_xcpt  = 1'b1;
    exp_eret  = 1'b0;
    for (int c = 0; c <= done_c + 1; c++) begin
      @(posedge clk);
      #1;
      bus_if.valid_i      = (c == 0) ? 1'b1 : (c <= done_c) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_if.csr_cmd_i    = (c == 0) ? cmd : 3'($urandom_range(1, 7));
      bus_if.csr_addr_i   = (c == 0) ? addr : 12'($urandom);
      bus_if.csr_data_i   = (c == 0) ? wdata : {$urandom, $urandom};
      bus_if.pc_i         = (c == 0) ? pc : {$urandom, $urandom};
      bus_if.csr_replay_i = (c >= 2 && c <= rep_end);
      bus_if.csr_stall_i  = !abort && (c >= resp) && (c < resp + nstall);
      bus_if.csr_rdata_i     = {$urandom, $urandom};
      bus_if.csr_evec_i      = {$urandom, $urandom};
      bus_if.csr_exception_i = 1'($urandom_range(0, 1));
      bus_if.csr_eret_i      = 1'($urandom_range(0, 1));
      if (c == cap_c && !abort && !tmo) begin
        exp_rdata = bus_if.csr_rdata_i;
        exp_evec  = bus_if.csr_evec_i;
        exp_xcpt  = bus_if.csr_exception_i;
        exp_eret  = bus_if.csr_eret_i;
      end
      #1;
      exp_req  = (c >= 1) && (c <= 2 * k - 1) && (c % 2 == 1);
      exp_busy = (c >= 1) && (c < done_c);
      exp_done = (c == done_c);
      if (bus_if.csr_req_valid_o) strobes++;
      n_checks++;
      if (bus_if.csr_req_valid_o !== exp_req) begin
        n_fail++;
        $display("FAIL %s req_valid cyc %0d: got %b want %b", name, c,
                 bus_if.csr_req_valid_o, exp_req);
      end
      n_checks++;
      if (bus_if.busy_o !== exp_busy) begin
        n_fail++;
        $display("FAIL %s busy cyc %0d: got %b want %b", name, c, bus_if.busy_o, exp_busy);
      end
      n_checks++;
      if (bus_if.done_o !== exp_done) begin
        n_fail++;
        $display("FAIL %s done cyc %0d: got %b want %b", name, c, bus_if.done_o, exp_done);
      end
      if (c >= 1 && c <= done_c) begin
        n_checks++;
        if ({bus_if.csr_rw_addr_o, bus_if.csr_rw_cmd_o, bus_if.csr_rw_data_o, bus_if.csr_pc_o}
            !== {addr, cmd, wdata, pc}) begin
          n_fail++;
          $display("FAIL %s latched cyc %0d: got %h/%h/%h/%h want %h/%h/%h/%h", name, c,
                   bus_if.csr_rw_addr_o, bus_if.csr_rw_cmd_o, bus_if.csr_rw_data_o,
                   bus_if.csr_pc_o, addr, cmd, wdata, pc);
        end
      end
      if (c == done_c) begin
        n_checks++;
        if (bus_if.xcpt_o !== exp_xcpt) begin
          n_fail++;
          $display("FAIL %s xcpt: got %b want %b", name, bus_if.xcpt_o, exp_xcpt);
        end
        if (!abort) begin
          n_checks++;
          if (bus_if.rdata_o !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s rdata: got %h want %h", name, bus_if.rdata_o, exp_rdata);
          end
        end
        if (!abort && !tmo) begin
          n_checks++;
          if ({bus_if.eret_o, bus_if.evec_o} !== {exp_eret, exp_evec}) begin
            n_fail++;
            $display("FAIL %s eret/evec: got %b/%h want %b/%h", name, bus_if.eret_o,
                     bus_if.evec_o, exp_eret, exp_evec);
          end
        end
      end
    end
    idle_inputs();
    n_checks++;
    if (strobes != k) begin
      n_fail++;
      $display("FAIL %s strobe count: got %0d want %0d", name, strobes, k);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({bus_if.csr_req_valid_o, bus_if.csr_rw_addr_o, bus_if.csr_rw_cmd_o,
         bus_if.csr_rw_data_o, bus_if.csr_pc_o, bus_if.busy_o, bus_if.done_o, bus_if.rdata_o,
         bus_if.xcpt_o, bus_if.eret_o, bus_if.evec_o} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got nonzero want all zero");
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    run_txn("basic", CMD_CSRRW, 12'h300, 64'hA5, 0, 0);
  endtask

  task automatic test_replay();
    run_txn("replay2", CMD_CSRRW, 12'h340, {$urandom, $urandom}, 2, 0);
    run_txn("replay_max", CMD_CSRRW, 12'h341, {$urandom, $urandom}, 100, 0);
  endtask

  task automatic test_stall();
    run_txn("stall10", 3'd2, 12'h7c0, {$urandom, $urandom}, 0, 10);
  endtask

  task automatic test_kill();
    // Kill during the issue cycle: strobe suppressed, back to idle.
    @(posedge clk);
    #1;
    bus_if.valid_i   = 1'b1;
    bus_if.csr_cmd_i = CMD_CSRRW;
    @(posedge clk);
    #1;
    bus_if.valid_i = 1'b0;
    bus_if.kill_i  = 1'b1;
    #1;
    n_checks++;
    if (bus_if.csr_req_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_issue strobe: got %b want 0", bus_if.csr_req_valid_o);
    end
    @(posedge clk);
    #1;
    bus_if.kill_i = 1'b0;
    #1;
    n_checks++;
    if ({bus_if.busy_o, bus_if.done_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL kill_issue idle: got busy/done %b%b want 00", bus_if.busy_o, bus_if.done_o);
    end
    // Kill in the response cycle.
    bus_if.valid_i   = 1'b1;
    bus_if.csr_cmd_i = CMD_CSRRW;
    @(posedge clk);
    #1;
    bus_if.valid_i = 1'b0;
    #1;
    n_checks++;
    if (bus_if.csr_req_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_resp strobe: got %b want 1", bus_if.csr_req_valid_o);
    end
    @(posedge clk);
    #1;
    bus_if.kill_i = 1'b1;
    @(posedge clk);
    #1;
    bus_if.kill_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({bus_if.busy_o, bus_if.done_o, bus_if.csr_req_valid_o} !== 3'b000) begin
        n_fail++;
        $display("FAIL kill_resp after %0d: got busy/done/req %b%b%b want 000", i,
                 bus_if.busy_o, bus_if.done_o, bus_if.csr_req_valid_o);
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    run_txn("after_kill", CMD_CSRRW, 12'h305, {$urandom, $urandom}, 1, 1);
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    bus_if.valid_i   = 1'b1;
    bus_if.csr_cmd_i = 3'd3;
    bus_if.csr_addr_i = 12'hABC;
    bus_if.csr_data_i = 64'h1234;
    bus_if.pc_i       = 64'h8000_0000;
    @(posedge clk);
    #1;
    bus_if.valid_i     = 1'b0;
    bus_if.csr_stall_i = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (bus_if.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid busy before reset: got %b want 1", bus_if.busy_o);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({bus_if.csr_req_valid_o, bus_if.csr_rw_addr_o, bus_if.csr_rw_cmd_o,
         bus_if.csr_rw_data_o, bus_if.csr_pc_o, bus_if.busy_o, bus_if.done_o, bus_if.rdata_o,
         bus_if.xcpt_o, bus_if.eret_o, bus_if.evec_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid outputs: got nonzero want all zero");
    end
    idle_inputs();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    n_checks++;
    if (bus_if.done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid done after release: got %b want 0", bus_if.done_o);
    end
    run_txn("after_reset", CMD_CSRRW, 12'h301, {$urandom, $urandom}, 0, 2);
  endtask

  task automatic test_ignore();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus_if.valid_i    = 1'b1;
      bus_if.csr_cmd_i  = CMD_NOPE;
      bus_if.csr_addr_i = 12'($urandom);
      #1;
      n_checks++;
      if ({bus_if.csr_req_valid_o, bus_if.busy_o, bus_if.done_o} !== 3'b000) begin
        n_fail++;
        $display("FAIL nope cyc %0d: got req/busy/done %b%b%b want 000", i,
                 bus_if.csr_req_valid_o, bus_if.busy_o, bus_if.done_o);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int nrep, nstall;
      nrep   = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 12) : $urandom_range(0, 3);
      nstall = $urandom_range(0, 7);
      run_txn("random", 3'($urandom_range(1, 7)), 12'($urandom), {$urandom, $urandom},
              nrep, nstall);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_replay();
    test_stall();
    test_ignore();
    test_kill();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "simulation did not finish");
  end

endmodule
